conv_engine: RTL and testbench



---
 rtl/conv_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_conv_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine
// Description : Two-layer CNN accelerator for a square grayscale image.
//               Layer 0: 3x3 zero-padded convolution with a fixed kernel,
//               bias, round-half-up and ReLU, written to L0 (csel=001).
//               Layer 1: 2x2 stride-2 max-pool of L0, written to L1
//               (csel=011). Layer 1 is only built when CONV_MAXPOOL_EN is
//               defined; otherwise the job ends after the last L0 write.
// Ports       : clk, reset (async, active-low)
//               ready/busy          - start request / job in progress
//               iaddr/idata         - image ROM, data valid one edge later
//               cwr/caddr_wr/cdata_wr - result memory write port
//               crd/caddr_rd/cdata_rd - result memory read port
//               csel                - 001 = L0, 011 = L1, 000 = idle
// Revision    : 1.0 - initial release
// ============================================================================
module conv_engine #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [11:0]       iaddr,
    input  logic [DATA_W-1:0] idata,
    output logic              cwr,
    output logic [11:0]       caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              crd,
    output logic [11:0]       caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic [2:0]        csel
);

    localparam int c_CW    = $clog2(IMG_W);
    localparam int c_AW    = 2 * c_CW;
    localparam int c_FRAC  = 16;
    localparam int c_PW    = 2 * DATA_W;
    localparam int c_ACC_W = c_PW + 4;

    localparam logic signed [DATA_W-1:0]  c_BIAS     = 20'sh01310;
    localparam logic signed [c_ACC_W-1:0] c_BIAS_ACC =
        {{(c_ACC_W-DATA_W-c_FRAC){c_BIAS[DATA_W-1]}}, c_BIAS, {c_FRAC{1'b0}}};
    localparam logic [c_CW+1:0] c_ONE = {{(c_CW+1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_L0_FETCH = 3'd1;
    localparam logic [2:0] S_L0_WRITE = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
`ifdef CONV_MAXPOOL_EN
    localparam logic [2:0] S_L1_READ  = 3'd4;
    localparam logic [2:0] S_L1_WRITE = 3'd5;
`endif

    function automatic logic signed [DATA_W-1:0] kcoef(input logic [3:0] k);
        case (k)
            4'd0:    kcoef = 20'sh0A89E;
            4'd1:    kcoef = 20'sh092D5;
            4'd2:    kcoef = 20'sh06D43;
            4'd3:    kcoef = 20'sh01004;
            4'd4:    kcoef = 20'shF8F71;
            4'd5:    kcoef = 20'shF6E54;
            4'd6:    kcoef = 20'shFA6D7;
            4'd7:    kcoef = 20'shFC834;
            4'd8:    kcoef = 20'shFAC19;
            default: kcoef = '0;
        endcase
    endfunction

    logic [2:0]                r_state;
    logic [3:0]                r_k;     // tap index being issued / phase
    logic [3:0]                r_kd;    // tap index whose data arrives now
    logic                      r_pv;    // issued tap was inside the image
    logic                      r_av;    // a read is in flight this cycle
    logic [c_CW-1:0]           r_x;
    logic [c_CW-1:0]           r_y;
    logic signed [c_ACC_W-1:0] r_acc;
`ifdef CONV_MAXPOOL_EN
    logic [c_CW-2:0]           r_i;
    logic [c_CW-2:0]           r_j;
    logic [DATA_W-1:0]         r_max;
`else
    logic                      w_unused_rd;
    assign w_unused_rd = ^cdata_rd;
`endif

    logic [1:0]               w_row;
    logic [1:0]               w_col;
    logic [c_CW+1:0]          w_yy;
    logic [c_CW+1:0]          w_xx;
    logic                     w_inb;
    logic [c_AW-1:0]          w_iaddr;
    logic signed [DATA_W-1:0] w_pix;
    logic signed [DATA_W-1:0] w_kc;
    logic signed [c_PW-1:0]   w_prod;
    logic [DATA_W-1:0]        w_round;
    logic [DATA_W-1:0]        w_relu;
    logic                     w_last_px;

    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_k)
            4'd0: begin w_row = 2'd0; w_col = 2'd0; end
            4'd1: begin w_row = 2'd0; w_col = 2'd1; end
            4'd2: begin w_row = 2'd0; w_col = 2'd2; end
            4'd3: begin w_row = 2'd1; w_col = 2'd0; end
            4'd4: begin w_row = 2'd1; w_col = 2'd1; end
            4'd5: begin w_row = 2'd1; w_col = 2'd2; end
            4'd6: begin w_row = 2'd2; w_col = 2'd0; end
            4'd7: begin w_row = 2'd2; w_col = 2'd1; end
            4'd8: begin w_row = 2'd2; w_col = 2'd2; end
            default: begin w_row = 2'd0; w_col = 2'd0; end
        endcase
    end

    // Neighbour coordinate = centre + offset - 1; going below 0 or past
    // IMG_W-1 sets one of the two guard bits, which marks the tap as padding.
    assign w_yy    = {2'b00, r_y} + {{c_CW{1'b0}}, w_row} - c_ONE;
    assign w_xx    = {2'b00, r_x} + {{c_CW{1'b0}}, w_col} - c_ONE;
    assign w_inb   = (w_yy[c_CW+1:c_CW] == 2'b00) && (w_xx[c_CW+1:c_CW] == 2'b00);
    assign w_iaddr = {w_yy[c_CW-1:0], w_xx[c_CW-1:0]};

    assign w_pix  = r_pv ? idata : '0;
    assign w_kc   = kcoef(r_kd);
    assign w_prod = w_pix * w_kc;

    // Round half up, then ReLU on the sign of the 4.16 result.
    assign w_round   = r_acc[c_FRAC+DATA_W-1:c_FRAC] + {{(DATA_W-1){1'b0}}, r_acc[c_FRAC-1]};
    assign w_relu    = w_round[DATA_W-1] ? '0 : w_round;
    assign w_last_px = (r_x == '1) && (r_y == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_kd     <= '0;
            r_pv     <= 1'b0;
            r_av     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            busy     <= 1'b0;
            iaddr    <= '0;
            cwr      <= 1'b0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            crd      <= 1'b0;
            caddr_rd <= '0;
            csel     <= 3'b000;
`ifdef CONV_MAXPOOL_EN
            r_i      <= '0;
            r_j      <= '0;
            r_max    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        busy    <= 1'b1;
                        r_state <= S_L0_FETCH;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_k     <= '0;
                        r_av    <= 1'b0;
                        r_acc   <= c_BIAS_ACC;
                        csel    <= 3'b001;
`ifdef CONV_MAXPOOL_EN
                        r_i     <= '0;
                        r_j     <= '0;
                        r_max   <= '0;
`endif
                    end
                end
                // Issue one tap per cycle and accumulate the previous tap's
                // data in the same cycle; one extra cycle drains the last.
                S_L0_FETCH: begin
                    cwr  <= 1'b0;
                    csel <= 3'b001;
                    if (r_k < 4'd9) begin
                        iaddr <= 12'(w_iaddr);
                        r_pv  <= w_inb;
                        r_kd  <= r_k;
                        r_av  <= 1'b1;
                        r_k   <= r_k + 4'd1;
                    end else begin
                        r_av    <= 1'b0;
                        r_state <= S_L0_WRITE;
                    end
                    if (r_av) begin
                        r_acc <= r_acc + {{(c_ACC_W-c_PW){w_prod[c_PW-1]}}, w_prod};
                    end
                end
                S_L0_WRITE: begin
                    cwr      <= 1'b1;
                    csel     <= 3'b001;
                    caddr_wr <= 12'({r_y, r_x});
                    cdata_wr <= w_relu;
                    r_acc    <= c_BIAS_ACC;
                    r_k      <= '0;
                    if (r_x == '1) begin
                        r_x <= '0;
                        r_y <= r_y + c_CW'(1);
                    end else begin
                        r_x <= r_x + c_CW'(1);
                    end
                    if (w_last_px) begin
`ifdef CONV_MAXPOOL_EN
                        r_state <= S_L1_READ;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_state <= S_L0_FETCH;
                    end
                end
`ifdef CONV_MAXPOOL_EN
                // Window tap k: row bit k[1], column bit k[0].
                S_L1_READ: begin
                    cwr  <= 1'b0;
                    csel <= 3'b001;
                    if (r_k < 4'd4) begin
                        crd      <= 1'b1;
                        caddr_rd <= 12'({r_j, r_k[1], r_i, r_k[0]});
                        r_av     <= 1'b1;
                        r_k      <= r_k + 4'd1;
                    end else begin
                        crd     <= 1'b0;
                        r_av    <= 1'b0;
                        r_state <= S_L1_WRITE;
                    end
                    if (r_av && (cdata_rd > r_max)) begin
                        r_max <= cdata_rd;
                    end
                end
                S_L1_WRITE: begin
                    cwr      <= 1'b1;
                    csel     <= 3'b011;
                    caddr_wr <= 12'({r_j, r_i});
                    cdata_wr <= r_max;
                    r_max    <= '0;
                    r_k      <= '0;
                    if (r_i == '1) begin
                        r_i <= '0;
                        r_j <= r_j + (c_CW-1)'(1);
                    end else begin
                        r_i <= r_i + (c_CW-1)'(1);
                    end
                    if ((r_i == '1) && (r_j == '1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_L1_READ;
                    end
                end
`endif
                // First cycle lets the final write be sampled; busy drops
                // on the following edge.
                S_DONE: begin
                    cwr  <= 1'b0;
                    crd  <= 1'b0;
                    csel <= 3'b000;
                    if (r_k == 4'd0) begin
                        r_k <= 4'd1;
                    end else begin
                        r_k     <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_engine
// Description : Self-checking bench for conv_engine. Image ROM and result
//               memory are modelled here; expected L0/L1 contents come from
//               a plain-arithmetic model of the convolution and max-pool.
//               The DUT is built with a 16x16 image to keep jobs short;
//               indices that are 64/65 on a 64-wide image are W/W+1 here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_engine;

    localparam int W      = 16;
    localparam int N      = W * W;
    localparam int H      = W / 2;
`ifdef CONV_MAXPOOL_EN
    localparam int MAXCYC = N * 11 + (N / 4) * 6 + 8;
`else
    localparam int MAXCYC = N * 11 + 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;

    logic [19:0] img    [0:4095];
    logic [19:0] l0     [0:4095];
    logic [19:0] l1     [0:1023];
    logic [19:0] exp_l0 [0:4095];
    logic [19:0] exp_l1 [0:1023];
    logic signed [19:0] kern [9] = '{20'sh0A89E, 20'sh092D5, 20'sh06D43,
                                     20'sh01004, 20'shF8F71, 20'shF6E54,
                                     20'shFA6D7, 20'shFC834, 20'shFAC19};
    localparam logic signed [19:0] BIAS = 20'sh01310;

    int checks = 0;
    int failures = 0;
    int cyc = 0, last_wr = 0, fall_edge = 0;
    int jobs = 0, late_wr = 0, conflicts = 0, bad_sel = 0, l1_sel_seen = 0;
    logic prev_busy = 1'b0;
    logic clr = 1'b0;

    conv_engine #(.IMG_W(W), .DATA_W(20)) dut (
        .clk(clk), .reset(rst_n), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign idata    = img[iaddr];
    assign cdata_rd = l0[caddr_rd];

    // Result memory plus protocol monitors.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) l0[i] <= 20'hAAAAA;
            for (int i = 0; i < 1024; i++) l1[i] <= 20'hAAAAA;
        end else if (cwr) begin
            last_wr <= cyc;
            if (csel == 3'b001) l0[caddr_wr] <= cdata_wr;
            else if (csel == 3'b011) l1[caddr_wr[9:0]] <= cdata_wr;
            else bad_sel <= bad_sel + 1;
            if (!busy) late_wr <= late_wr + 1;
        end
        if (cwr && crd) conflicts <= conflicts + 1;
        if (csel == 3'b011) l1_sel_seen <= l1_sel_seen + 1;
        if (busy && !prev_busy) jobs <= jobs + 1;
        if (!busy && prev_busy) fall_edge <= cyc - 1;
        prev_busy <= busy;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [19:0] ref_px(input int y, input int x);
        longint acc;
        longint r;
        logic [63:0] rb;
        acc = longint'(BIAS) * 65536;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (y + dy >= 0 && y + dy < W && x + dx >= 0 && x + dx < W)
                    acc += longint'($signed(img[(y + dy) * W + (x + dx)]))
                         * longint'(kern[(dy + 1) * 3 + (dx + 1)]);
            end
        end
        r  = (acc + 64'sd32768) >>> 16;
        rb = r;
        return rb[19] ? 20'h00000 : rb[19:0];
    endfunction

    task automatic build_model();
        logic [19:0] m;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                exp_l0[y * W + x] = ref_px(y, x);
        for (int j = 0; j < H; j++) begin
            for (int i = 0; i < H; i++) begin
                m = 20'h0;
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        if (exp_l0[(2 * j + a) * W + 2 * i + b] > m)
                            m = exp_l0[(2 * j + a) * W + 2 * i + b];
                exp_l1[j * H + i] = m;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_l0[%0d]", tag, i), 32'(l0[i]), 32'(exp_l0[i]));
`ifdef CONV_MAXPOOL_EN
        for (int i = 0; i < N / 4; i++)
            chk($sformatf("%s_l1[%0d]", tag, i), 32'(l1[i]), 32'(exp_l1[i]));
`endif
    endtask

    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic run_job(input string tag, input int hold);
        int j0, lw0, cf0, bs0, n;
        j0 = jobs; lw0 = late_wr; cf0 = conflicts; bs0 = bad_sel;
        @(negedge clk) ready = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        repeat (hold) @(negedge clk);
        ready = 1'b0;
        n = 0;
        while (busy && n < MAXCYC + 100) begin @(negedge clk); n++; end
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_duration"}, 32'(n + hold <= MAXCYC), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, "_jobs"}, 32'(jobs - j0), 32'd1);
        chk({tag, "_late_wr"}, 32'(late_wr - lw0), 32'd0);
        chk({tag, "_wr_rd_overlap"}, 32'(conflicts - cf0), 32'd0);
        chk({tag, "_bad_sel"}, 32'(bad_sel - bs0), 32'd0);
        chk({tag, "_fall_after_last_wr"}, 32'(fall_edge), 32'(last_wr + 1));
    endtask

    initial begin
        logic [19:0] t;
        int n;
        rst_n = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4096; i++) img[i] = 20'h0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cwr", 32'(cwr), 32'd0);
        chk("rst_crd", 32'(crd), 32'd0);
        chk("rst_csel", 32'(csel), 32'd0);
        chk("rst_iaddr", 32'(iaddr), 32'd0);
        chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
        chk("rst_cdata_wr", 32'(cdata_wr), 32'd0);
        chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // All-zero image: every output is the bias.
        clear_mem();
        build_model();
        run_job("zero", 0);
        chk("zero_l0_0", 32'(l0[0]), 32'h01310);
        chk("zero_l0_last", 32'(l0[N - 1]), 32'h01310);
        compare_all("zero");

        // Impulse of 1.0 at (0,0).
        img[0] = 20'h10000;
        clear_mem();
        build_model();
        run_job("imp", 0);
        chk("imp_l0_0_relu", 32'(l0[0]), 32'h00000);
        chk("imp_l0_1", 32'(l0[1]), 32'h02314);
        chk("imp_l0_W", 32'(l0[W]), 32'h0A5E5);
        chk("imp_l0_W1", 32'(l0[W + 1]), 32'h0BBAE);
`ifdef CONV_MAXPOOL_EN
        chk("imp_l1_0", 32'(l1[0]), 32'h0BBAE);
        chk("imp_l1_1", 32'(l1[1]), 32'h01310);
`endif
        compare_all("imp");

        // Impulse of 0.5: K1/2 = 0x496A.8 rounds up; K0/2 = 0x544F exact.
        img[0] = 20'h08000;
        clear_mem();
        build_model();
        run_job("rnd", 0);
        chk("rnd_l0_W", 32'(l0[W]), 32'h05C7B);
        chk("rnd_l0_W1", 32'(l0[W + 1]), 32'h0675F);
        compare_all("rnd");

        // Random image in [-1.0, 1.0); ready held 3 cycles after busy.
        for (int i = 0; i < N; i++) begin
            t = 20'($urandom_range(0, 32'h1FFFF));
            img[i] = t - 20'h10000;
        end
        clear_mem();
        build_model();
        run_job("rand", 3);
        compare_all("rand");
        for (int k = 0; k < W; k++) begin
            chk($sformatf("border_top[%0d]", k), 32'(l0[k]), 32'(exp_l0[k]));
            chk($sformatf("border_bot[%0d]", k), 32'(l0[(W - 1) * W + k]), 32'(exp_l0[(W - 1) * W + k]));
            chk($sformatf("border_lft[%0d]", k), 32'(l0[k * W]), 32'(exp_l0[k * W]));
            chk($sformatf("border_rgt[%0d]", k), 32'(l0[k * W + W - 1]), 32'(exp_l0[k * W + W - 1]));
        end

        // Second pulse of ready: identical job.
        clear_mem();
        run_job("repeat", 0);
        compare_all("repeat");

        // Abort mid-Layer-0, then restart.
        clear_mem();
        @(negedge clk) ready = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk("abort_busy_rise", 32'(busy), 32'd1);
        ready = 1'b0;
        repeat (300) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cwr", 32'(cwr), 32'd0);
        chk("abort_crd", 32'(crd), 32'd0);
        chk("abort_csel", 32'(csel), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        clear_mem();
        run_job("restart", 0);
        compare_all("restart");

`ifndef CONV_MAXPOOL_EN
        chk("no_l1_select", 32'(l1_sel_seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
